mdu: RTL



---
 rtl/mdu.sv | 137 +++++++++++++
 1 files changed

// File: rtl/mdu.sv
// mdu: iterative 32-bit multiply/divide unit that owns the HI/LO register pair.
// An arithmetic op takes 33 cycles (32 CALC iterations + 1 FIX) regardless of
// operand values; mthi/mtlo write HI/LO in a single cycle without going busy.
//
// Handshake: start is sampled only on a rising edge where busy=0; busy is a
// registered flag that rises the cycle after issue and drops at the edge that
// writes the results, so any start seen while busy=1 is dropped entirely.
module mdu (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [2:0]  MDUOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t      state;
  logic [4:0]  cnt;
  logic        is_div;
  logic        div_zero;
  logic        neg_lo;     // product sign (mult) or quotient sign (div)
  logic        neg_hi;     // remainder sign (div only)
  logic [31:0] a_orig;     // original dividend, returned in HI on divide-by-zero
  logic [32:0] opnd;       // multiplicand or divisor magnitude
  logic [63:0] acc;        // {hi, lo} product accumulator or {rem, quot}

  logic        op_signed;
  logic [32:0] a_mag;
  logic [32:0] b_mag;
  logic [32:0] mul_sum;
  logic [63:0] mul_next;
  logic [33:0] div_trial;
  logic [63:0] div_next;
  logic [63:0] prod_fix;
  logic [31:0] fix_hi;
  logic [31:0] fix_lo;

  assign dbg_state = state;

  // Operand magnitudes (33-bit so |-2^31| is exact) and one iteration of each algorithm.
  always_comb begin
    op_signed = ~MDUOp[0];
    a_mag     = (op_signed && A[31]) ? (33'd0 - {A[31], A}) : {1'b0, A};
    b_mag     = (op_signed && B[31]) ? (33'd0 - {B[31], B}) : {1'b0, B};
    // Shift-add: conditionally add multiplicand to the upper half, then shift right.
    mul_sum   = {1'b0, acc[63:32]} + (acc[0] ? opnd : 33'd0);
    mul_next  = {mul_sum, acc[31:1]};
    // Restoring divide: shift {rem,quot} left, keep the subtraction if it did not go negative.
    div_trial = {1'b0, acc[63:31]} - {1'b0, opnd};
    if (!div_trial[33]) div_next = {div_trial[31:0], acc[30:0], 1'b1};
    else                div_next = {acc[62:0], 1'b0};
  end

  // Sign fixups and divide-by-zero override applied on the FIX cycle.
  always_comb begin
    prod_fix = neg_lo ? (64'd0 - acc) : acc;
    if (!is_div) begin
      fix_hi = prod_fix[63:32];
      fix_lo = prod_fix[31:0];
    end else if (div_zero) begin
      fix_hi = a_orig;
      fix_lo = 32'hFFFF_FFFF;
    end else begin
      fix_hi = neg_hi ? (32'd0 - acc[63:32]) : acc[63:32];
      fix_lo = neg_lo ? (32'd0 - acc[31:0])  : acc[31:0];
    end
  end

  // Control FSM, datapath registers and the HI/LO pair.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= IDLE;
      busy     <= 1'b0;
      cnt      <= 5'd0;
      is_div   <= 1'b0;
      div_zero <= 1'b0;
      neg_lo   <= 1'b0;
      neg_hi   <= 1'b0;
      a_orig   <= 32'd0;
      opnd     <= 33'd0;
      acc      <= 64'd0;
      HI       <= 32'd0;
      LO       <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            case (MDUOp)
              3'b000, 3'b001, 3'b010, 3'b011: begin
                state    <= CALC;
                busy     <= 1'b1;
                cnt      <= 5'd0;
                is_div   <= MDUOp[1];
                div_zero <= MDUOp[1] && (B == 32'd0);
                a_orig   <= A;
                neg_lo   <= op_signed && (A[31] ^ B[31]);
                neg_hi   <= op_signed && A[31];
                // Divide loads the dividend into the low half; multiply loads the multiplier.
                acc      <= {31'd0, (MDUOp[1] ? a_mag : b_mag)};
                opnd     <= MDUOp[1] ? b_mag : a_mag;
              end
              3'b100:  HI <= A;
              3'b101:  LO <= A;
              default: ;
            endcase
          end
        end
        CALC: begin
          acc <= is_div ? div_next : mul_next;
          cnt <= cnt + 5'd1;
          if (cnt == 5'd31) state <= FIX;
        end
        FIX: begin
          HI    <= fix_hi;
          LO    <= fix_lo;
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
